seg7_scan_driver: RTL

- Consumer end of the stopwatch digit interface.
- Takes four BCD digits plus the half-period toggle flag from the stopwatch counter and drives a 4-digit common-anode multiplexed 7-segment display.
- Snapshots the digits once per frame, scans the anodes round-robin, and inserts a per-slot anti-ghosting blank.
- Sits between the stopwatch core and the board display pins.

---
 rtl/seg7_scan_driver.sv | 104 ++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode multiplexed 7-segment scanner with per-slot blanking.
// Define DP_BLINK_EN to gate the slot-0 decimal point with the shadowed ptflag.
module seg7_scan_driver #(
  parameter int         SCAN_DIV  = 50000,
  parameter int         BLANK_CYC = 500,
  parameter logic [3:0] DP_MASK   = 4'b0101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic       ptflag,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLK  = DW'(BLANK_CYC);

  logic [DW-1:0] div;
  logic [1:0]    slot;
  logic [3:0]    sd [4];
  logic          spt;
  logic          snap;
  logic          dp_on;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign snap = (slot == 2'd0) && (div == '0);

`ifdef DP_BLINK_EN
  assign dp_on = DP_MASK[slot] & ((slot != 2'd0) | spt);
`else
  logic unused_pt;
  assign unused_pt = spt;
  assign dp_on = DP_MASK[slot];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      slot <= 2'd0;
      spt  <= 1'b0;
      for (int i = 0; i < 4; i++) sd[i] <= 4'd0;
    end else begin
      if (div == DMAX) begin
        div  <= '0;
        slot <= slot + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      if (snap) begin
        sd[0] <= digit1;
        sd[1] <= digit2;
        sd[2] <= digit3;
        sd[3] <= digit4;
        spt   <= ptflag;
      end
    end
  end

  // Blank window hides the slot change and shadow update from the lit digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap;
      if (div < BLK) begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b1000 >> slot);
        seg <= ~dec(sd[slot]);
        dp  <= ~dp_on;
      end
    end
  end

endmodule
